enigma_step_controller: RTL and testbench
=========================================

# enigma_step_controller

Clocked stepping controller for the three-rotor Enigma stack. It owns the left, middle and right rotor position registers (each 0–25), loads user-selected start positions, and on each keypress advances the stack with true Enigma notch/turnover and middle-rotor double-step behaviour. After the positions settle it emits a one-cycle strobe so the downstream substitution path can encipher the pressed letter against stable positions.

## Interface
Parameters:
- NOTCH_R, default 21 (V): right-rotor turnover position.
- NOTCH_M, default 4 (E): middle-rotor turnover position.
- NOTCH_L, default 16 (Q): left-rotor notch. Carried as an output flag only; nothing sits left of it.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- key_press  in  1  keypress level, synchronous to clk; a rising edge requests one step.
- load_init  in  1  synchronous load of the start positions; priority over everything except resetn.
- init_l, init_m, init_r  in  5 each  start positions; any value >25 loads 0.
- pos_l, pos_m, pos_r  out  7 each  current positions, zero-extended, always 0–25.
- cipher_en  out  1  one-cycle strobe meaning positions are final for this keypress.
- busy  out  1  high from accepted keypress until key_press is seen low.
- at_notch_l  out  1  high when pos_l == NOTCH_L (combinational from the register).

## Operation
- States: IDLE, STEP, STROBE, WAIT_REL. Reset state is IDLE.
- Reset values: pos_l/m/r = 0, cipher_en = 0, busy = 0, and the key edge-detect register = 0.
- IDLE: a key_press rising edge (key_press=1, previous sample=0) moves to STEP and sets busy.
- STEP: one-cycle update. All stepping decisions use the pre-step values:
  - right always increments;
  - middle increments if pos_r == NOTCH_R, or if pos_m == NOTCH_M (the double-step);
  - left increments if pos_m == NOTCH_M.
  - Then go to STROBE.
- Increment: value 25 wraps to 0. Use 5-bit arithmetic internally, zero-extended to 7 bits on output. A register never holds a value >25.
- STROBE: cipher_en = 1 for exactly this cycle, then go to WAIT_REL.
- WAIT_REL: stay while key_press = 1. When key_press = 0, clear busy and go to IDLE. A held key produces exactly one step.
- load_init = 1, in any state:
  - on the next edge each pos takes its init value (0 if >25);
  - FSM goes to IDLE, busy = 0, cipher_en = 0;
  - the edge-detect register samples key_press, so a key held through the load does not step.
- Edges on key_press while busy are ignored; no queueing.

## Timing
- Cycle 0: key_press is sampled 1 with previous sample 0. Next state is STEP.
- Cycle 1 (STEP): new positions are visible after this edge.
- Cycle 2 (STROBE): cipher_en = 1, positions unchanged.
- Latency from keypress sample to cipher_en is 2 cycles. Positions are stable from the end of STEP until the next accepted keypress or load.
- Minimum keypress period is 4 cycles: press, STEP, STROBE, and one low cycle in WAIT_REL.
- load_init and a key edge in the same cycle: the load wins, and no step or strobe occurs.
- resetn asserted mid-STEP or mid-STROBE: all outputs clear immediately (asynchronous), and no strobe follows.

## Test plan
- Reset, then a single press: positions go 0,0,0 -> 0,0,1. cipher_en is high exactly 2 cycles after the press sample. busy clears one cycle after key_press falls.
- Double-step: load 0,3,20 (A,D,U), then press four times. Positions must be ADV, AEW, BFX, BFY, i.e. (0,3,21), (0,4,22), (1,5,23), (1,5,24).
- Full wrap: load 25,25,25, press once -> (25,25,0); no turnover because 25 is not a notch. Load 25,4,21, press once -> (0,5,22).
- Out-of-range load: init = 31,26,25 -> positions 0,0,25. Hold key_press high for 20 cycles -> exactly one step to 0,0,0 and one cipher_en pulse.
- Collision and reset: assert load_init in the same cycle as a key edge -> init values load, no cipher_en. Drop resetn during STEP -> all positions 0, FSM in IDLE, busy 0.
- Press while busy: a second rising edge during WAIT_REL (key_press low for one cycle, then high again) is stepped only after IDLE is re-entered. Total steps equal the accepted presses.

Source files
------------

// File: rtl/enigma_step_controller.sv
// Three-rotor Enigma stepping controller: owns rotor positions, applies notch
// turnover and middle-rotor double-step per keypress, then strobes cipher_en.
module enigma_step_controller #(
  parameter int unsigned NOTCH_R = 21,
  parameter int unsigned NOTCH_M = 4,
  parameter int unsigned NOTCH_L = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_press,
  input  logic       load_init,
  input  logic [4:0] init_l,
  input  logic [4:0] init_m,
  input  logic [4:0] init_r,
  output logic [6:0] pos_l,
  output logic [6:0] pos_m,
  output logic [6:0] pos_r,
  output logic       cipher_en,
  output logic       busy,
  output logic       at_notch_l
);

  typedef enum logic [1:0] {IDLE, STEP, STROBE, WAIT_REL} state_e;

  localparam logic [4:0] NR = 5'(NOTCH_R);
  localparam logic [4:0] NM = 5'(NOTCH_M);
  localparam logic [4:0] NL = 5'(NOTCH_L);

  function automatic logic [4:0] inc26(input logic [4:0] v);
    return (v >= 5'd25) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] clamp26(input logic [4:0] v);
    return (v > 5'd25) ? 5'd0 : v;
  endfunction

  state_e     state_q, state_d;
  logic [4:0] pos_l_q, pos_l_d;
  logic [4:0] pos_m_q, pos_m_d;
  logic [4:0] pos_r_q, pos_r_d;
  logic       key_q, key_d;

  // NOTE: every variable gets a default before any branch so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    pos_l_d = pos_l_q;
    pos_m_d = pos_m_q;
    pos_r_d = pos_r_q;
    key_d   = key_press;

    if (load_init) begin
      pos_l_d = clamp26(init_l);
      pos_m_d = clamp26(init_m);
      pos_r_d = clamp26(init_r);
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:     if (key_press && !key_q) state_d = STEP;
        STEP: begin
          // All turnover decisions look at the pre-step positions.
          pos_r_d = inc26(pos_r_q);
          if (pos_r_q == NR || pos_m_q == NM) pos_m_d = inc26(pos_m_q);
          if (pos_m_q == NM)                  pos_l_d = inc26(pos_l_q);
          state_d = STROBE;
        end
        STROBE:   state_d = WAIT_REL;
        WAIT_REL: if (!key_press) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      pos_l_q <= 5'd0;
      pos_m_q <= 5'd0;
      pos_r_q <= 5'd0;
      key_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_l_q <= pos_l_d;
      pos_m_q <= pos_m_d;
      pos_r_q <= pos_r_d;
      key_q   <= key_d;
    end
  end

  assign pos_l      = {2'b00, pos_l_q};
  assign pos_m      = {2'b00, pos_m_q};
  assign pos_r      = {2'b00, pos_r_q};
  assign cipher_en  = (state_q == STROBE);
  assign busy       = (state_q != IDLE);
  assign at_notch_l = (pos_l_q == NL);

endmodule

// File: tb/tb_enigma_step_controller.sv
// Self-checking bench for enigma_step_controller: directed test-plan steps plus
// randomized loads/presses against an arithmetic rotor model.
module tb_enigma_step_controller;

  logic       clk = 1'b0;
  logic       resetn;
  logic       key_press;
  logic       load_init;
  logic [4:0] init_l, init_m, init_r;
  logic [6:0] pos_l, pos_m, pos_r;
  logic       cipher_en, busy, at_notch_l;

  int tests = 0;
  int fails = 0;
  int ml, mm, mr;  // model rotor positions

  enigma_step_controller dut (
    .clk(clk), .resetn(resetn), .key_press(key_press), .load_init(load_init),
    .init_l(init_l), .init_m(init_m), .init_r(init_r),
    .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r),
    .cipher_en(cipher_en), .busy(busy), .at_notch_l(at_notch_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pk(input int l, input int m, input int r);
    return {11'd0, 7'(l), 7'(m), 7'(r)};
  endfunction

  task automatic check_pos(input string tag);
    check(tag, {11'd0, pos_l, pos_m, pos_r}, pk(ml, mm, mr));
    check({tag, "_notch"}, 32'(at_notch_l), 32'(ml == 16));
  endtask

  // Enigma advance: right always moves; middle on right notch or its own notch
  // (double step); left when the middle sits on its notch.
  task automatic model_step();
    int nl, nm, nr;
    nr = (mr + 1) % 26;
    nm = (mr == 21 || mm == 4) ? (mm + 1) % 26 : mm;
    nl = (mm == 4) ? (ml + 1) % 26 : ml;
    ml = nl; mm = nm; mr = nr;
  endtask

  task automatic load(input int l, input int m, input int r);
    load_init = 1'b1;
    init_l = 5'(l); init_m = 5'(m); init_r = 5'(r);
    tick();
    load_init = 1'b0;
    ml = (l > 25) ? 0 : l;
    mm = (m > 25) ? 0 : m;
    mr = (r > 25) ? 0 : r;
    check_pos("load_pos");
    check("load_busy", 32'(busy), 0);
    check("load_cen", 32'(cipher_en), 0);
  endtask

  // One press held for 'hold' cycles after the strobe (hold >= 1), then release.
  task automatic press(input int hold);
    int pl, pm, pr;
    pl = ml; pm = mm; pr = mr;
    key_press = 1'b1;
    tick();
    check("press_busy", 32'(busy), 1);
    check("press_cen_early", 32'(cipher_en), 0);
    check("press_pos_hold", pk(pl, pm, pr), {11'd0, pos_l, pos_m, pos_r});
    tick();
    model_step();
    check("strobe_cen", 32'(cipher_en), 1);
    check_pos("strobe_pos");
    for (int i = 0; i < hold; i++) begin
      tick();
      check("held_cen", 32'(cipher_en), 0);
      check("held_busy", 32'(busy), 1);
    end
    key_press = 1'b0;
    tick();
    check("release_busy", 32'(busy), 0);
    check("release_cen", 32'(cipher_en), 0);
    check_pos("release_pos");
  endtask

  initial begin
    int exp_ds [4][3];
    exp_ds = '{'{0, 3, 21}, '{0, 4, 22}, '{1, 5, 23}, '{1, 5, 24}};

    resetn = 1'b0; key_press = 1'b0; load_init = 1'b0;
    init_l = '0; init_m = '0; init_r = '0;
    ml = 0; mm = 0; mr = 0;
    #1;
    check_pos("reset_pos");
    check("reset_busy", 32'(busy), 0);
    check("reset_cen", 32'(cipher_en), 0);
    tick(); tick();
    resetn = 1'b1;
    tick();

    // Single press from reset: 0,0,0 -> 0,0,1.
    press(1);
    check("single_pos", {11'd0, pos_l, pos_m, pos_r}, pk(0, 0, 1));

    // Double-step: ADU -> ADV, AEW, BFX, BFY.
    load(0, 3, 20);
    for (int i = 0; i < 4; i++) begin
      press(1);
      check("dstep_const", {11'd0, pos_l, pos_m, pos_r},
            pk(exp_ds[i][0], exp_ds[i][1], exp_ds[i][2]));
    end

    // Wrap cases.
    load(25, 25, 25);
    press(2);
    check("wrap_zzz", {11'd0, pos_l, pos_m, pos_r}, pk(25, 25, 0));
    load(25, 4, 21);
    press(1);
    check("wrap_turn", {11'd0, pos_l, pos_m, pos_r}, pk(0, 5, 22));

    // Left notch flag.
    load(16, 0, 0);
    check("notch_l_set", 32'(at_notch_l), 1);

    // Out-of-range load then a 20-cycle held key -> exactly one step.
    load(31, 26, 25);
    check("oor_pos", {11'd0, pos_l, pos_m, pos_r}, pk(0, 0, 25));
    press(18);
    check("hold20_pos", {11'd0, pos_l, pos_m, pos_r}, pk(0, 0, 0));

    // Load collides with a key edge: load wins, held key never steps.
    key_press = 1'b1;
    load(7, 8, 9);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("coll_cen", 32'(cipher_en), 0);
      check("coll_busy", 32'(busy), 0);
    end
    check_pos("coll_pos");
    key_press = 1'b0;
    tick();

    // Edge arriving while busy is ignored.
    key_press = 1'b1;
    tick();                       // STEP
    key_press = 1'b0;
    tick();                       // STROBE
    model_step();
    check("ign_cen", 32'(cipher_en), 1);
    key_press = 1'b1;             // new edge while busy
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ign_cen_after", 32'(cipher_en), 0);
    end
    check_pos("ign_pos");
    key_press = 1'b0;
    tick();
    check("ign_idle", 32'(busy), 0);
    // Release for one cycle then press again: accepted after IDLE.
    press(1);

    // Reset during STEP clears everything, no strobe follows.
    load(3, 4, 5);
    key_press = 1'b1;
    tick();                       // STEP
    resetn = 1'b0;
    #1;
    ml = 0; mm = 0; mr = 0;
    check_pos("rst_step_pos");
    check("rst_step_busy", 32'(busy), 0);
    check("rst_step_cen", 32'(cipher_en), 0);
    key_press = 1'b0;
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_strobe", 32'(cipher_en), 0);
    end
    check_pos("rst_after_pos");

    // Randomized loads and presses against the model.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 4) == 0)
        load(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)));
      else
        press(int'($urandom_range(1, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
